axi4_lite_slave_regs: RTL and testbench

//  AXI4-Lite slave register file; terminates the write/read transactions issued by the team's AXI4-Lite master.

---
 rtl/axi4_lite_pkg.sv | 25 ++
 rtl/axi4_lite_wr_collector.sv | 65 ++++++
 rtl/axi4_lite_slave_regs.sv | 182 ++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by the slave register file and the master.
//   RESP_*     : AXI response encodings
//   wr_state_e : write channel FSM states
//   rd_state_e : read channel FSM states
//   clog2      : ceiling log2 for sizing localparams
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axi4_lite_wr_collector.sv
// Collects the AW and W halves of an AXI4-Lite write, which may arrive in
// either order with any skew, and presents them together once both are held.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_idle           : write FSM is idle and allowed to accept
//   b_done            : B handshake; releases both holds
//   awaddr/awvalid/awready, wdata/wstrb/wvalid/wready : AXI write channels
//   wr_go             : both halves held while idle; commit this cycle
//   wr_addr/wr_data/wr_strb : held write transaction
module axi4_lite_wr_collector #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_idle,
   input  logic            b_done,
   input  logic [AW-1:0]   awaddr,
   input  logic            awvalid,
   output logic            awready,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wstrb,
   input  logic            wvalid,
   output logic            wready,
   output logic            wr_go,
   output logic [AW-1:0]   wr_addr,
   output logic [DW-1:0]   wr_data,
   output logic [DW/8-1:0] wr_strb
);

   logic            aw_held_q, w_held_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic [DW/8-1:0] strb_q;

   assign awready = wr_idle && !aw_held_q;
   assign wready  = wr_idle && !w_held_q;
   assign wr_go   = wr_idle && aw_held_q && w_held_q;
   assign wr_addr = addr_q;
   assign wr_data = data_q;
   assign wr_strb = strb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else if (b_done) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
      end else begin
         if (awvalid && awready) begin
            aw_held_q <= 1'b1;
            addr_q    <= awaddr;
         end
         if (wvalid && wready) begin
            w_held_q <= 1'b1;
            data_q   <= wdata;
            strb_q   <= wstrb;
         end
      end
   end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register file with byte-strobe writes, optional read-only
// status slots fed from hw_in, and SLVERR for out-of-range or read-only writes.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*    : AXI4-Lite slave channels (PROT ignored)
//   reg_out  : flat register contents, reg i at [i*DW +: DW]
//   hw_in    : status inputs, used only for RO_MASK slots
//   wr_pulse : one-cycle strobe, bit i high while reg i's new value is on reg_out
module axi4_lite_slave_regs #(
   parameter int unsigned         C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned         NUM_REGS           = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
   input  logic                               S_AXI_ACLK,
   input  logic                               S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
   input  logic [2:0]                         S_AXI_AWPROT,
   input  logic                               S_AXI_AWVALID,
   output logic                               S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
   input  logic                               S_AXI_WVALID,
   output logic                               S_AXI_WREADY,
   output logic [1:0]                         S_AXI_BRESP,
   output logic                               S_AXI_BVALID,
   input  logic                               S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
   input  logic [2:0]                         S_AXI_ARPROT,
   input  logic                               S_AXI_ARVALID,
   output logic                               S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
   output logic [1:0]                         S_AXI_RRESP,
   output logic                               S_AXI_RVALID,
   input  logic                               S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_in,
   output logic [NUM_REGS-1:0]                wr_pulse
);
   import axi4_lite_pkg::*;

   localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW       = DW / 8;
   localparam int unsigned ADDR_LSB = clog2(SW);
   localparam int unsigned IW       = clog2(NUM_REGS);

   logic [DW-1:0] regs_q [NUM_REGS];
   logic [DW-1:0] hw_arr [NUM_REGS];

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign reg_out[i*DW +: DW] = regs_q[i];
      assign hw_arr[i]           = hw_in[i*DW +: DW];
   end

   // Keeps READY low for the first cycle after reset as well as during it.
   logic alive_q;

   // ---------------- write path ----------------
   wr_state_e     wr_state_q, wr_state_d;
   logic          wr_idle, wr_go, b_done, w_ok;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] wr_strb;
   logic [IW-1:0] w_idx;
   logic [1:0]    bresp_q;
   logic [NUM_REGS-1:0] wr_pulse_q;

   assign wr_idle = alive_q && (wr_state_q == W_IDLE);
   assign b_done  = (wr_state_q == W_RESP) && S_AXI_BREADY;

   axi4_lite_wr_collector #(
      .AW (AW),
      .DW (DW)
   ) u_wr_collector (
      .clk     (S_AXI_ACLK),
      .rst_n   (S_AXI_ARESETN),
      .wr_idle (wr_idle),
      .b_done  (b_done),
      .awaddr  (S_AXI_AWADDR),
      .awvalid (S_AXI_AWVALID),
      .awready (S_AXI_AWREADY),
      .wdata   (S_AXI_WDATA),
      .wstrb   (S_AXI_WSTRB),
      .wvalid  (S_AXI_WVALID),
      .wready  (S_AXI_WREADY),
      .wr_go   (wr_go),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb)
   );

   assign w_idx = wr_addr[ADDR_LSB +: IW];
   assign w_ok  = !(|wr_addr[AW-1:ADDR_LSB+IW]) && !RO_MASK[w_idx];

   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         W_IDLE:  if (wr_go) wr_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         alive_q    <= 1'b0;
         wr_state_q <= W_IDLE;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         alive_q    <= 1'b1;
         wr_state_q <= wr_state_d;
         wr_pulse_q <= '0;
         if (wr_go) begin
            bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_ok) begin
               // Pulse even for WSTRB=0 so fabric sees every accepted write.
               wr_pulse_q <= NUM_REGS'(1) << w_idx;
               for (int b = 0; b < SW; b++) begin
                  if (wr_strb[b]) regs_q[w_idx][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   assign S_AXI_BVALID = (wr_state_q == W_RESP);
   assign S_AXI_BRESP  = bresp_q;
   assign wr_pulse     = wr_pulse_q;

   // ---------------- read path ----------------
   rd_state_e     rd_state_q, rd_state_d;
   logic          ar_hs, r_oor;
   logic [IW-1:0] r_idx;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    rresp_q, rresp_d;

   assign S_AXI_ARREADY = alive_q && (rd_state_q == R_IDLE);
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
   assign r_idx         = S_AXI_ARADDR[ADDR_LSB +: IW];
   assign r_oor         = |S_AXI_ARADDR[AW-1:ADDR_LSB+IW];

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = '0;
      rresp_d    = RESP_SLVERR;
      if (!r_oor) begin
         rresp_d = RESP_OKAY;
         rdata_d = RO_MASK[r_idx] ? hw_arr[r_idx] : regs_q[r_idx];
      end
      case (rd_state_q)
         R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Sampling regs_q here gives the pre-write value when a commit hits the same edge.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         if (ar_hs) begin
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
         end
      end
   end

   assign S_AXI_RVALID = (rd_state_q == R_DATA);
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[ADDR_LSB-1:0],
                        S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs (DW=32, NUM_REGS=8, slot 7 read-only).
// Expected B and R responses are queued when stimulus is issued and popped by
// a monitor when the DUT presents the response.
module tb_axi4_lite_slave_regs;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 8;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [AW-1:0]   awaddr = '0, araddr = '0;
   logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [DW-1:0]   wdata = '0;
   logic [3:0]      wstrb = '0;
   logic            awready, wready, bvalid, arready, rvalid;
   logic [1:0]      bresp, rresp;
   logic [DW-1:0]   rdata;
   logic [NR*DW-1:0] reg_out;
   logic [NR*DW-1:0] hw_in = '0;
   logic [NR-1:0]   wr_pulse;

   always #5 clk = ~clk;

   axi4_lite_slave_regs #(
      .C_S_AXI_ADDR_WIDTH (AW),
      .C_S_AXI_DATA_WIDTH (DW),
      .NUM_REGS           (NR),
      .RO_MASK            (8'h80)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (3'b000),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (3'b000),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_out       (reg_out),
      .hw_in         (hw_in),
      .wr_pulse      (wr_pulse)
   );

   int            n_cmp = 0;
   int            n_err = 0;
   logic [1:0]    exp_b [$];
   logic [33:0]   exp_r [$];
   logic [DW-1:0] model [NR];
   logic [NR-1:0] ro_mask = 8'h80;
   logic [NR-1:0] pulse_seen = '0;
   logic [NR-1:0] exp_pulse = '0;

   task automatic monitor();
      logic [1:0]  eb;
      logic [33:0] er;
      forever begin
         @(negedge clk);
         if (rstn) begin
            pulse_seen = pulse_seen | wr_pulse;
            if (bvalid && bready) begin
               n_cmp++;
               if (exp_b.size() == 0) begin
                  n_err++;
                  $display("FAIL b_unexpected: got bresp=%b, none expected", bresp);
               end else begin
                  eb = exp_b.pop_front();
                  if (bresp !== eb) begin
                     n_err++;
                     $display("FAIL bresp: got %b want %b", bresp, eb);
                  end
               end
            end
            if (rvalid && rready) begin
               n_cmp++;
               if (exp_r.size() == 0) begin
                  n_err++;
                  $display("FAIL r_unexpected: got rdata=%h rresp=%b", rdata, rresp);
               end else begin
                  er = exp_r.pop_front();
                  if ({rresp, rdata} !== er) begin
                     n_err++;
                     $display("FAIL rdata: got %b/%h want %b/%h", rresp, rdata, er[33:32],
                              er[31:0]);
                  end
               end
            end
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_aw(input logic [AW-1:0] a);
      bit hs = 0;
      int n = 0;
      awaddr = a;
      awvalid = 1'b1;
      while (!hs && n < 30) begin
         @(negedge clk);
         hs = awready;
         @(posedge clk);
         #1;
         n++;
      end
      awvalid = 1'b0;
      if (!hs) begin
         n_cmp++;
         n_err++;
         $display("FAIL aw_timeout: awready=%b after %0d cycles, want 1", awready, n);
      end
   endtask

   task automatic do_w(input logic [DW-1:0] d, input logic [3:0] s);
      bit hs = 0;
      int n = 0;
      wdata = d;
      wstrb = s;
      wvalid = 1'b1;
      while (!hs && n < 30) begin
         @(negedge clk);
         hs = wready;
         @(posedge clk);
         #1;
         n++;
      end
      wvalid = 1'b0;
      if (!hs) begin
         n_cmp++;
         n_err++;
         $display("FAIL w_timeout: wready=%b after %0d cycles, want 1", wready, n);
      end
   endtask

   // lag > 0: W starts lag cycles after AW; lag < 0: AW starts -lag cycles after W.
   task automatic write_issue(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [3:0] s, input int lag);
      int idx = int'(a[4:2]);
      bit ok  = (a[AW-1:5] == '0) && !ro_mask[idx];
      exp_b.push_back(ok ? 2'b00 : 2'b10);
      exp_pulse = ok ? (8'h01 << idx) : 8'h00;
      if (ok) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
      pulse_seen = '0;
      fork
         begin
            cyc(lag < 0 ? -lag : 0);
            do_aw(a);
         end
         begin
            cyc(lag > 0 ? lag : 0);
            do_w(d, s);
         end
      join
   endtask

   task automatic wait_b();
      bit seen = 0;
      int n = 0;
      bready = 1'b1;
      while (!seen && n < 50) begin
         @(negedge clk);
         seen = bvalid;
         if (!seen) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      @(posedge clk);
      #1;
      bready = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL b_timeout: bvalid=%b, want 1", bvalid);
      end
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int lag);
      write_issue(a, d, s, lag);
      wait_b();
      cyc(2);
      n_cmp++;
      if (pulse_seen !== exp_pulse) begin
         n_err++;
         $display("FAIL wr_pulse @%h: got %b want %b", a, pulse_seen, exp_pulse);
      end
   endtask

   task automatic ar_handshake(input logic [AW-1:0] a);
      bit hs = 0;
      int n = 0;
      araddr = a;
      arvalid = 1'b1;
      while (!hs && n < 30) begin
         @(negedge clk);
         hs = arready;
         @(posedge clk);
         #1;
         n++;
      end
      arvalid = 1'b0;
      if (!hs) begin
         n_cmp++;
         n_err++;
         $display("FAIL ar_timeout: arready=%b, want 1", arready);
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [1:0] er);
      bit seen = 0;
      int n = 0;
      exp_r.push_back({er, ed});
      ar_handshake(a);
      rready = 1'b1;
      while (!seen && n < 50) begin
         @(negedge clk);
         seen = rvalid;
         if (!seen) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      @(posedge clk);
      #1;
      rready = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL r_timeout @%h: rvalid=%b, want 1", a, rvalid);
      end
   endtask

   task automatic axi_read_m(input logic [AW-1:0] a);
      int idx = int'(a[4:2]);
      if (a[AW-1:5] != '0)  axi_read(a, '0, 2'b10);
      else if (ro_mask[idx]) axi_read(a, hw_in[idx*DW +: DW], 2'b00);
      else                   axi_read(a, model[idx], 2'b00);
   endtask

   task automatic test_reset();
      for (int i = 0; i < NR; i++) model[i] = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({awready, wready, arready} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
      end
      n_cmp++;
      if ({bvalid, rvalid, bresp, rresp, wr_pulse} !== '0 || rdata !== '0 || reg_out !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: bv=%b rv=%b br=%b rr=%b rd=%h wp=%b want all 0",
                  bvalid, rvalid, bresp, rresp, rdata, wr_pulse);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int a = 0; a < 32; a += 4) axi_read(AW'(a), '0, 2'b00);
   endtask

   task automatic test_single_write();
      write_issue(32'h04, 32'hDEADBEEF, 4'hF, 3);
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b0) begin
         n_err++;
         $display("FAIL bvalid_early: got %b want 0", bvalid);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bvalid, wr_pulse} !== {1'b1, 8'h02} || reg_out[63:32] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL commit_cycle: bvalid=%b wr_pulse=%b reg1=%h want 1/00000010/deadbeef",
                  bvalid, wr_pulse, reg_out[63:32]);
      end
      wait_b();
      axi_read(32'h04, 32'hDEADBEEF, 2'b00);
   endtask

   task automatic test_strobe();
      axi_write(32'h04, 32'h11223344, 4'h5, 0);
      axi_read(32'h04, 32'hDE22BE44, 2'b00);
      axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0);
      axi_write(32'h04, 32'h11223344, 4'h5, -3);
      axi_read(32'h04, 32'hDE22BE44, 2'b00);
      axi_write(32'h08, 32'hFFFFFFFF, 4'h0, 1);
      axi_read(32'h08, 32'h0, 2'b00);
   endtask

   task automatic test_out_of_range();
      logic [NR*DW-1:0] snap = reg_out;
      axi_write(32'h40, 32'h55AA55AA, 4'hF, 0);
      n_cmp++;
      if (reg_out !== snap) begin
         n_err++;
         $display("FAIL oor_reg_out: got %h want %h", reg_out, snap);
      end
      axi_read(32'h40, 32'h0, 2'b10);
      axi_read_m(32'h07);
   endtask

   task automatic test_b_stall();
      logic [1:0] snap;
      bit seen = 0;
      write_issue(32'h08, 32'h0BADF00D, 4'hF, 0);
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = bvalid;
      end
      @(posedge clk);
      #1;
      snap = bresp;
      n_cmp++;
      if (!seen || snap !== 2'b00) begin
         n_err++;
         $display("FAIL stall_b_start: bvalid=%b bresp=%b want 1/00", bvalid, snap);
      end
      axi_read_m(32'h04);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({bvalid, bresp, awready, wready} !== {1'b1, snap, 2'b00}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: bv=%b br=%b awr=%b wr=%b want 1/%b/0/0",
                     i, bvalid, bresp, awready, wready, snap);
         end
      end
      @(posedge clk);
      #1;
      wait_b();
      axi_write(32'h0C, 32'h12345678, 4'hF, 1);
      axi_read_m(32'h0C);
      axi_read_m(32'h08);
   endtask

   task automatic test_ro_and_reset();
      bit seen = 0;
      hw_in[7*DW +: DW] = 32'hCAFEF00D;
      axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, 0);
      axi_read(32'h1C, 32'hCAFEF00D, 2'b00);
      ar_handshake(32'h04);
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = rvalid;
      end
      #2;
      rstn = 1'b0;
      #1;
      exp_r.delete();
      for (int i = 0; i < NR; i++) model[i] = '0;
      n_cmp++;
      if (!seen || rvalid !== 1'b0 || arready !== 1'b0 || reg_out !== '0) begin
         n_err++;
         $display("FAIL reset_mid_read: seen=%b rvalid=%b arready=%b want 1/0/0",
                  seen, rvalid, arready);
      end
      cyc(3);
      rstn = 1'b1;
      rready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_r[%0d]: rvalid=%b want 0", i, rvalid);
         end
      end
      @(posedge clk);
      #1;
      rready = 1'b0;
      axi_read_m(32'h04);
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single_write();
      test_strobe();
      test_out_of_range();
      test_b_stall();
      test_ro_and_reset();
      cyc(3);
      n_cmp++;
      if (exp_b.size() != 0 || exp_r.size() != 0) begin
         n_err++;
         $display("FAIL leftover: b=%0d r=%0d pending, want 0/0", exp_b.size(), exp_r.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
